apa102_serializer: RTL and testbench



---
 rtl/apa102_serializer.sv | 132 +++++++++++++
 tb/tb_apa102_serializer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_serializer.sv
// APA102/SK9822 bit serializer: one 32-bit word per valid/ack handshake, MSB-first on led_clk/led_data.
// Optional frame counter output enabled by defining APA102_FRAME_CNT_EN.
module apa102_serializer #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       framing,
    input  logic       se_frame,
    input  logic [4:0] dat_glo,
    input  logic [7:0] dat_red,
    input  logic [7:0] dat_grn,
    input  logic [7:0] dat_blu,
    input  logic       valid,
    output logic       ack,
`ifdef APA102_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic       led_clk,
    output logic       led_data
);

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned WORD_W  = 32;
    localparam logic [PHASE_W-1:0] DIV_M1 = PHASE_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   shift_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [4:0]          bit_q;
    logic                led_clk_q;
    logic                ack_q;
    logic [WORD_W-1:0]   word_d;
    logic                phase_end;
    logic                end_of_word;
    logic                cap;

    // Word formation and capture qualification
    always_comb begin
        word_d = {3'b111, dat_glo, dat_blu, dat_grn, dat_red};
        if (framing) begin
            word_d = se_frame ? {WORD_W{1'b1}} : {WORD_W{1'b0}};
        end
        phase_end   = (phase_q == DIV_M1);
        end_of_word = (state_q == HI) && phase_end && (bit_q == 5'd0);
        cap         = valid && !ack_q && ((state_q == IDLE) || end_of_word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            led_clk_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= cap;
            if (cap) begin
                shift_q   <= word_d;
                bit_q     <= 5'd31;
                phase_q   <= '0;
                led_clk_q <= 1'b0;
                state_q   <= LO;
            end else begin
                case (state_q)
                    IDLE: led_clk_q <= 1'b0;
                    LO: begin
                        if (phase_end) begin
                            phase_q   <= '0;
                            led_clk_q <= 1'b1;
                            state_q   <= HI;
                        end else begin
                            phase_q <= phase_q + PHASE_W'(1);
                        end
                    end
                    HI: begin
                        if (phase_end) begin
                            phase_q   <= '0;
                            led_clk_q <= 1'b0;
                            if (bit_q != 5'd0) begin
                                bit_q   <= bit_q - 5'd1;
                                shift_q <= {shift_q[WORD_W-2:0], 1'b0};
                                state_q <= LO;
                            end else begin
                                // Word done with nothing queued: park with data low
                                shift_q <= '0;
                                state_q <= IDLE;
                            end
                        end else begin
                            phase_q <= phase_q + PHASE_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef APA102_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic        end_tag_q;

    // Counts completed end frames; the tag is taken when the word is latched
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            end_tag_q   <= 1'b0;
        end else begin
            if (end_of_word && end_tag_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (cap) begin
                end_tag_q <= framing && se_frame;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign ack      = ack_q;
    assign led_clk  = led_clk_q;
    assign led_data = shift_q[WORD_W-1];

endmodule

// File: tb/tb_apa102_serializer.sv
// Self-checking bench for apa102_serializer: two instances (CLK_DIV=1 and CLK_DIV=4) checked against a word-level model.
module tb_apa102_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       framing, se_frame;
    logic [4:0] glo;
    logic [7:0] red, grn, blu;
    logic       valid1, valid4;
    logic       ack1, lclk1, ldat1;
    logic       ack4, lclk4, ldat4;
`ifdef APA102_FRAME_CNT_EN
    logic [15:0] fc1, fc4;
`endif

    always #5 clk = ~clk;

    apa102_serializer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .framing(framing), .se_frame(se_frame),
        .dat_glo(glo), .dat_red(red), .dat_grn(grn), .dat_blu(blu),
        .valid(valid1), .ack(ack1),
`ifdef APA102_FRAME_CNT_EN
        .frame_cnt(fc1),
`endif
        .led_clk(lclk1), .led_data(ldat1)
    );

    apa102_serializer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .framing(framing), .se_frame(se_frame),
        .dat_glo(glo), .dat_red(red), .dat_grn(grn), .dat_blu(blu),
        .valid(valid4), .ack(ack4),
`ifdef APA102_FRAME_CNT_EN
        .frame_cnt(fc4),
`endif
        .led_clk(lclk4), .led_data(ldat4)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitors: LED-side view of each string
    bit prev_clk1, prev_dat1, prev_ack1, prev_clk4, prev_dat4, prev_ack4;
    bit bits1[$], bits4[$];
    int acks1[$], acks4[$];
    int hi1[$], lo1[$], hi4[$], lo4[$];
    int run1 = 0, run4 = 0;
    int fall1 = 0, fall4 = 0;
    int hold_err1 = 0, hold_err4 = 0;
    int ack_dbl1 = 0, ack_dbl4 = 0;

    always @(negedge clk) begin
        if (!prev_clk1 && lclk1) bits1.push_back(ldat1);
        if (prev_clk1 && lclk1 && (ldat1 != prev_dat1)) hold_err1++;
        if (prev_clk1 && !lclk1) fall1 = cyc;
        if (ack1) begin
            if (prev_ack1) ack_dbl1++;
            acks1.push_back(cyc);
        end
        if (lclk1 == prev_clk1) run1++;
        else begin
            if (prev_clk1) hi1.push_back(run1); else lo1.push_back(run1);
            run1 = 1;
        end
        if (!prev_clk4 && lclk4) bits4.push_back(ldat4);
        if (prev_clk4 && lclk4 && (ldat4 != prev_dat4)) hold_err4++;
        if (prev_clk4 && !lclk4) fall4 = cyc;
        if (ack4) begin
            if (prev_ack4) ack_dbl4++;
            acks4.push_back(cyc);
        end
        if (lclk4 == prev_clk4) run4++;
        else begin
            if (prev_clk4) hi4.push_back(run4); else lo4.push_back(run4);
            run4 = 1;
        end
        prev_clk1 = lclk1; prev_dat1 = ldat1; prev_ack1 = ack1;
        prev_clk4 = lclk4; prev_dat4 = ldat4; prev_ack4 = ack4;
    end

    function automatic logic [31:0] model_word(input logic fr, input logic se, input logic [4:0] g5,
                                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if (fr) return se ? 32'hFFFF_FFFF : 32'h0000_0000;
        return (32'd7 << 29) | (32'(g5) << 24) | (32'(b) << 16) | (32'(g) << 8) | 32'(r);
    endfunction

    function automatic logic [31:0] gather(input bit q[$], input int base);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) begin
            if (base + i < q.size()) w = (w << 1) | 32'(q[base + i]);
            else w = w << 1;
        end
        return w;
    endfunction

    task automatic clear_mon();
        bits1.delete(); bits4.delete(); acks1.delete(); acks4.delete();
        hi1.delete(); lo1.delete(); hi4.delete(); lo4.delete();
        hold_err1 = 0; hold_err4 = 0; ack_dbl1 = 0; ack_dbl4 = 0;
    endtask

    task automatic set_word(input logic fr, input logic se, input logic [4:0] g5,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        framing = fr; se_frame = se; glo = g5; red = r; grn = g; blu = b;
    endtask

    task automatic wait_ack1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack4(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack4) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
        set_word(1'b0, 1'b0, 5'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if ({lclk1, ldat1, ack1, lclk4, ldat4, ack4} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got outputs=%b expected 000000", i, {lclk1, ldat1, ack1, lclk4, ldat4, ack4});
            end
        end
    endtask

    task automatic test_single_word();
        for (int it = 0; it < 3; it++) begin
            logic [31:0] exp;
            bit ok;
            int a;
            if (it == 0) set_word(1'b0, 1'b0, 5'h1F, 8'h12, 8'h34, 8'h56);
            else set_word(1'b0, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            exp = model_word(framing, se_frame, glo, red, grn, blu);
            clear_mon();
            valid1 = 1'b1;
            wait_ack1(ok);
            a = cyc;
            valid1 = 1'b0;
            set_word(1'b1, 1'b1, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            repeat (80) @(negedge clk);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL single_ack_timeout got none expected ack"); end
            vectors++;
            if (bits1.size() != 32) begin miscompares++; $display("FAIL single_rises got %0d expected 32", bits1.size()); end
            vectors++;
            if (gather(bits1, 0) !== exp) begin miscompares++; $display("FAIL single_bits got %h expected %h", gather(bits1, 0), exp); end
            vectors++;
            if (acks1.size() != 1 || ack_dbl1 != 0) begin miscompares++; $display("FAIL single_acks got %0d expected 1", acks1.size()); end
            vectors++;
            if (fall1 - a != 64) begin miscompares++; $display("FAIL single_duration got %0d expected 64", fall1 - a); end
            vectors++;
            if (hold_err1 != 0) begin miscompares++; $display("FAIL single_hold got %0d expected 0", hold_err1); end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 2; it++) begin
            logic [31:0] exp [3];
            bit ok [3];
            logic [4:0] g5;
            logic [7:0] r, g, b;
            if (it == 0) begin g5 = 5'h03; r = 8'h12; g = 8'h34; b = 8'h56; end
            else begin g5 = 5'($urandom); r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
            clear_mon();
            for (int w = 0; w < 3; w++) begin
                if (w == 0) set_word(1'b1, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                else if (w == 1) set_word(1'b0, 1'b1, g5, r, g, b);
                else set_word(1'b1, 1'b1, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                exp[w] = model_word(framing, se_frame, glo, red, grn, blu);
                valid1 = 1'b1;
                wait_ack1(ok[w]);
            end
            valid1 = 1'b0;
            repeat (80) @(negedge clk);
            vectors++;
            if (!(ok[0] && ok[1] && ok[2])) begin miscompares++; $display("FAIL b2b_ack_timeout got %b%b%b expected 111", ok[0], ok[1], ok[2]); end
            vectors++;
            if (bits1.size() != 96) begin miscompares++; $display("FAIL b2b_rises got %0d expected 96", bits1.size()); end
            for (int w = 0; w < 3; w++) begin
                vectors++;
                if (gather(bits1, 32 * w) !== exp[w]) begin
                    miscompares++; $display("FAIL b2b_word%0d got %h expected %h", w, gather(bits1, 32 * w), exp[w]);
                end
            end
            vectors++;
            if (acks1.size() != 3 || ack_dbl1 != 0) begin miscompares++; $display("FAIL b2b_acks got %0d expected 3", acks1.size()); end
            else begin
                vectors++;
                if (acks1[1] - acks1[0] != 64 || acks1[2] - acks1[1] != 64) begin
                    miscompares++; $display("FAIL b2b_ack_spacing got %0d,%0d expected 64,64", acks1[1] - acks1[0], acks1[2] - acks1[1]);
                end
            end
            vectors++;
            if (hi1.size() != 96 || lo1.size() != 96) begin
                miscompares++; $display("FAIL b2b_runs got hi=%0d lo=%0d expected 96,96", hi1.size(), lo1.size());
            end else begin
                int bad = 0;
                for (int k = 0; k < 96; k++) if (hi1[k] != 1) bad++;
                for (int k = 1; k < 96; k++) if (lo1[k] != 1) bad++;
                vectors++;
                if (bad != 0) begin miscompares++; $display("FAIL b2b_contiguous got %0d bad phases expected 0", bad); end
            end
        end
    endtask

    task automatic test_clk_div4();
        logic [31:0] exp;
        bit ok;
        int a;
        int bad = 0;
        set_word(1'b0, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        exp = model_word(framing, se_frame, glo, red, grn, blu);
        clear_mon();
        valid4 = 1'b1;
        wait_ack4(ok);
        a = cyc;
        valid4 = 1'b0;
        set_word(1'b1, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (300) @(negedge clk);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL div4_ack_timeout got none expected ack"); end
        vectors++;
        if (gather(bits4, 0) !== exp || bits4.size() != 32) begin
            miscompares++; $display("FAIL div4_bits got %h (%0d rises) expected %h (32)", gather(bits4, 0), bits4.size(), exp);
        end
        vectors++;
        if (hi4.size() != 32 || lo4.size() != 32) begin
            miscompares++; $display("FAIL div4_runs got hi=%0d lo=%0d expected 32,32", hi4.size(), lo4.size());
        end else begin
            for (int k = 0; k < 32; k++) if (hi4[k] != 4) bad++;
            for (int k = 1; k < 32; k++) if (lo4[k] != 4) bad++;
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL div4_phase_len got %0d bad phases expected 0", bad); end
        end
        vectors++;
        if (fall4 - a != 256) begin miscompares++; $display("FAIL div4_duration got %0d expected 256", fall4 - a); end
        vectors++;
        if (hold_err4 != 0 || acks4.size() != 1) begin
            miscompares++; $display("FAIL div4_hold_ack got hold=%0d acks=%0d expected 0,1", hold_err4, acks4.size());
        end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] exp;
        bit ok;
        bit reached = 1'b0;
        set_word(1'b0, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        clear_mon();
        valid1 = 1'b1;
        wait_ack1(ok);
        valid1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bits1.size() >= 15) begin reached = 1'b1; break; end
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (!(ok && reached)) begin miscompares++; $display("FAIL rst_mid_setup got ack=%b reached=%b expected 1,1", ok, reached); end
        vectors++;
        if ({lclk1, ldat1, ack1} !== 3'b000) begin
            miscompares++; $display("FAIL rst_mid_outputs got %b expected 000", {lclk1, ldat1, ack1});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({lclk1, ldat1, ack1} !== 3'b000) begin
            miscompares++; $display("FAIL rst_mid_quiet got %b expected 000", {lclk1, ldat1, ack1});
        end
        set_word(1'b0, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        exp = model_word(framing, se_frame, glo, red, grn, blu);
        clear_mon();
        valid1 = 1'b1;
        wait_ack1(ok);
        valid1 = 1'b0;
        repeat (80) @(negedge clk);
        vectors++;
        if (!ok || bits1.size() != 32 || gather(bits1, 0) !== exp) begin
            miscompares++; $display("FAIL rst_mid_recover got %h (%0d rises) expected %h (32)", gather(bits1, 0), bits1.size(), exp);
        end
    endtask

`ifdef APA102_FRAME_CNT_EN
    task automatic test_frame_cnt();
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            for (int w = 0; w < 3; w++) begin
                if (w == 0) set_word(1'b1, 1'b0, 5'd0, 8'd0, 8'd0, 8'd0);
                else if (w == 1) set_word(1'b0, 1'b0, 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                else set_word(1'b1, 1'b1, 5'd0, 8'd0, 8'd0, 8'd0);
                valid1 = 1'b1;
                wait_ack1(ok);
            end
            valid1 = 1'b0;
            repeat (70) @(negedge clk);
        end
        vectors++;
        if (fc1 !== 16'd3) begin miscompares++; $display("FAIL frame_cnt_3 got %0d expected 3", fc1); end
        force dut1.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut1.frame_cnt_q;
        set_word(1'b1, 1'b1, 5'd0, 8'd0, 8'd0, 8'd0);
        valid1 = 1'b1;
        wait_ack1(ok);
        valid1 = 1'b0;
        repeat (70) @(negedge clk);
        vectors++;
        if (fc1 !== 16'd0) begin miscompares++; $display("FAIL frame_cnt_wrap got %h expected 0000", fc1); end
    endtask
`endif

    initial begin
        rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
        set_word(1'b0, 1'b0, 5'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_clk_div4();
        test_reset_mid_word();
`ifdef APA102_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
